// File: rtl/bp_pkg.sv
// Shared types and defaults for the branch resolver and its pending-prediction queue.
// Nothing here is registered; it only fixes widths and entry layout.
package bp_pkg;

  localparam int BP_DEPTH = 4;
  localparam int BP_CNT_W = 16;
  localparam int BP_PTR_W = $clog2(BP_DEPTH);

  // One queued prediction; room to add a tag or PC field later.
  typedef struct packed {
    logic taken;
  } bp_entry_t;

endpackage

// File: rtl/bp_pending_fifo.sv
// In-order DEPTH-entry queue of captured predictions; write/pop take effect at the clock edge.
// The caller never writes when full and never pops when empty; flush empties it in one cycle.
import bp_pkg::*;

module bp_pending_fifo #(
  parameter int DEPTH = BP_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr,
  input  bp_entry_t        wr_data,
  input  logic             rd,
  output bp_entry_t        rd_data,
  output logic [OCC_W-1:0] count,
  output logic             empty
);

  bp_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap on their own; the occupancy count separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr, rd})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);

endmodule

// File: rtl/branch_resolver.sv
// Issues predictor requests for fetched branches and resolves them in order; fetch to pred_valid is 3 cycles.
// fetch_ready drops once in-flight plus queued branches reach DEPTH or during flush; resolve_ready needs a captured entry.
import bp_pkg::*;

module branch_resolver #(
  parameter int DEPTH = BP_DEPTH,
  parameter int CNT_W = BP_CNT_W,
  localparam int PEND_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  output logic              request,
  input  logic              prediction,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              resolve_valid,
  input  logic              resolve_taken,
  output logic              resolve_ready,
  input  logic              flush,
  output logic              result,
  output logic              taken,
  output logic              mispredict,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  resolve_count,
  output logic [CNT_W-1:0]  mispredict_count
);

  logic              req_d;
  logic              fetch_acc;
  logic              res_acc;
  logic              capture;
  bp_entry_t         head;
  bp_entry_t         new_entry;
  logic [PEND_W-1:0] q_count;
  logic              q_empty;

  // Requests still travelling through the predictor count against capacity,
  // so a capture can never find the queue full.
  assign pending       = q_count + PEND_W'(request) + PEND_W'(req_d);
  assign fetch_ready   = (pending < PEND_W'(DEPTH)) && !flush;
  assign fetch_acc     = fetch_valid && fetch_ready;
  assign resolve_ready = !q_empty;
  assign res_acc       = resolve_valid && resolve_ready;
  assign capture       = req_d && !flush;
  assign new_entry     = '{taken: prediction};

  bp_pending_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr      (capture),
    .wr_data (new_entry),
    .rd      (res_acc),
    .rd_data (head),
    .count   (q_count),
    .empty   (q_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      request          <= 1'b0;
      req_d            <= 1'b0;
      pred_valid       <= 1'b0;
      pred_taken       <= 1'b0;
      result           <= 1'b0;
      taken            <= 1'b0;
      mispredict       <= 1'b0;
      resolve_count    <= '0;
      mispredict_count <= '0;
    end else begin
      request    <= fetch_acc;
      // A request already on the wire still reaches the predictor, but a flush
      // forgets it here so its answer is dropped.
      req_d      <= request && !flush;
      pred_valid <= capture;
      pred_taken <= capture && prediction;

      result     <= res_acc;
      taken      <= res_acc && resolve_taken;
      mispredict <= res_acc && (head.taken != resolve_taken);

      if (res_acc && (resolve_count != '1))
        resolve_count <= resolve_count + CNT_W'(1);
      if (res_acc && (head.taken != resolve_taken) && (mispredict_count != '1))
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with a 2-bit saturating-counter predictor model.
// Expected predictions and resolve outcomes are queued at stimulus time and popped by a monitor.
module tb_branch_resolver;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 2;
  localparam int PEND_W = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst;
  logic              fetch_valid;
  logic              fetch_ready;
  logic              request;
  logic              prediction;
  logic              pred_valid;
  logic              pred_taken;
  logic              resolve_valid;
  logic              resolve_taken;
  logic              resolve_ready;
  logic              flush;
  logic              result;
  logic              taken;
  logic              mispredict;
  logic [PEND_W-1:0] pending;
  logic [CNT_W-1:0]  resolve_count;
  logic [CNT_W-1:0]  mispredict_count;

  int checks = 0;
  int errors = 0;

  bit       pq[$];
  bit [1:0] rq[$];
  bit       pe;
  bit [1:0] re;
  logic [1:0] pctr;

  branch_resolver #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_valid      (fetch_valid),
    .fetch_ready      (fetch_ready),
    .request          (request),
    .prediction       (prediction),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
    .resolve_valid    (resolve_valid),
    .resolve_taken    (resolve_taken),
    .resolve_ready    (resolve_ready),
    .flush            (flush),
    .result           (result),
    .taken            (taken),
    .mispredict       (mispredict),
    .pending          (pending),
    .resolve_count    (resolve_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predictor: 2-bit saturating counter, starts strongly taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pctr       <= 2'd3;
      prediction <= 1'b0;
    end else begin
      if (request) prediction <= pctr[1];
      if (result) begin
        if (taken && pctr != 2'd3)       pctr <= pctr + 2'd1;
        else if (!taken && pctr != 2'd0) pctr <= pctr - 2'd1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && pred_valid) begin
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL pred_valid_unexpected actual=1 expected=0");
      end else begin
        pe = pq.pop_front();
        if (pred_taken !== pe) begin
          errors++;
          $display("FAIL pred_taken actual=%0b expected=%0b", pred_taken, pe);
        end
      end
    end
    if (!rst && result) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected actual=1 expected=0");
      end else begin
        re = rq.pop_front();
        if ({taken, mispredict} !== re) begin
          errors++;
          $display("FAIL resolve_out actual=%0b%0b expected=%0b", taken, mispredict, re);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    fetch_valid = 1'b0;
    resolve_valid = 1'b0;
    resolve_taken = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    neg();
    chk("rst_request", int'(request), 0);
    chk("rst_pred_valid", int'(pred_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_mispredict", int'(mispredict), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_resolve_count", int'(resolve_count), 0);
    chk("rst_mispredict_count", int'(mispredict_count), 0);
    chk("rst_fetch_ready", int'(fetch_ready), 1);
    chk("rst_resolve_ready", int'(resolve_ready), 0);

    // Single branch: request in cycle 1, capture visible in cycle 3.
    cyc(); fetch_valid = 1'b1; pq.push_back(1'b1); neg();
    chk("t1_fetch_ready", int'(fetch_ready), 1);
    cyc(); fetch_valid = 1'b0; neg();
    chk("t1_request_c1", int'(request), 1);
    chk("t1_pending_c1", int'(pending), 1);
    cyc(); neg();
    chk("t1_request_c2", int'(request), 0);
    chk("t1_pending_c2", int'(pending), 1);
    chk("t1_resolve_ready_c2", int'(resolve_ready), 0);
    cyc(); neg();
    chk("t1_resolve_ready_c3", int'(resolve_ready), 1);
    chk("t1_pending_c3", int'(pending), 1);

    // Resolve not-taken against a taken prediction.
    cyc(); resolve_valid = 1'b1; resolve_taken = 1'b0; rq.push_back(2'b01); neg();
    cyc(); resolve_valid = 1'b0; neg();
    chk("t2_resolve_count", int'(resolve_count), 1);
    chk("t2_mispredict_count", int'(mispredict_count), 1);
    chk("t2_pending", int'(pending), 0);
    chk("t2_resolve_ready", int'(resolve_ready), 0);
    // Counter now 2: still predicts taken.
    cyc(); fetch_valid = 1'b1; pq.push_back(1'b1); neg();
    cyc(); fetch_valid = 1'b0;
    cyc(); cyc(); neg();
    chk("t2b_resolve_ready", int'(resolve_ready), 1);
    cyc(); resolve_valid = 1'b1; resolve_taken = 1'b1; rq.push_back(2'b10);
    cyc(); resolve_valid = 1'b0; neg();
    chk("t2b_resolve_count", int'(resolve_count), 2);
    chk("t2b_mispredict_count", int'(mispredict_count), 1);

    // Four back-to-back fetches fill the window.
    for (int k = 0; k < 5; k++) begin
      cyc(); fetch_valid = 1'b1;
      if (k < 4) pq.push_back(1'b1);
      neg();
      chk("t3_fetch_ready", int'(fetch_ready), (k < 4) ? 1 : 0);
      if (k == 4) chk("t3_pending_full", int'(pending), 4);
    end
    cyc(); fetch_valid = 1'b0; neg();
    cyc(); neg();
    cyc(); resolve_valid = 1'b1; resolve_taken = 1'b1; rq.push_back(2'b10); neg();
    chk("t3_resolve_ready", int'(resolve_ready), 1);
    chk("t3_pending_before", int'(pending), 4);
    cyc(); resolve_valid = 1'b0; neg();
    chk("t3_fetch_ready_after", int'(fetch_ready), 1);
    chk("t3_pending_after", int'(pending), 3);
    chk("t3_resolve_count", int'(resolve_count), 3);
    chk("t3_mispredict_count", int'(mispredict_count), 1);

    // Drain two as not-taken: counter falls to 1, resolve_count saturates.
    cyc(); resolve_valid = 1'b1; resolve_taken = 1'b0; rq.push_back(2'b01);
    cyc(); rq.push_back(2'b01);
    cyc(); resolve_valid = 1'b0; fetch_valid = 1'b1; pq.push_back(1'b0); neg();
    chk("t4_resolve_count_sat", int'(resolve_count), 3);
    chk("t4_mispredict_count", int'(mispredict_count), 3);
    chk("t4_pending_start", int'(pending), 1);
    cyc(); fetch_valid = 1'b0; neg();
    // Capture, resolve and fetch all on the same edge.
    cyc(); fetch_valid = 1'b1; pq.push_back(1'b0);
    resolve_valid = 1'b1; resolve_taken = 1'b1; rq.push_back(2'b10); neg();
    chk("t4_pending_before", int'(pending), 2);
    cyc(); fetch_valid = 1'b0; resolve_valid = 1'b0; neg();
    chk("t4_pending_after", int'(pending), 2);
    chk("t4_resolve_ready", int'(resolve_ready), 1);

    // Flush with two queued, one in flight and a concurrent resolve.
    cyc(); fetch_valid = 1'b1; neg();
    cyc(); fetch_valid = 1'b0; flush = 1'b1;
    resolve_valid = 1'b1; resolve_taken = 1'b1; rq.push_back(2'b11); neg();
    chk("t5_fetch_ready_flush", int'(fetch_ready), 0);
    chk("t5_pending_before", int'(pending), 3);
    cyc(); flush = 1'b0; resolve_valid = 1'b0; neg();
    chk("t5_pending_after", int'(pending), 0);
    chk("t5_resolve_ready", int'(resolve_ready), 0);
    chk("t5_mispredict_count_sat", int'(mispredict_count), 3);
    cyc(); neg();
    chk("t5_no_pred_valid_a", int'(pred_valid), 0);
    cyc(); neg();
    chk("t5_no_pred_valid_b", int'(pred_valid), 0);
    chk("t5_pending_idle", int'(pending), 0);

    // Reset while request, result and mispredict are all high.
    cyc(); fetch_valid = 1'b1; pq.push_back(1'b1);
    cyc(); fetch_valid = 1'b0;
    cyc(); cyc(); resolve_valid = 1'b1; resolve_taken = 1'b0; fetch_valid = 1'b1; neg();
    chk("t6_resolve_ready", int'(resolve_ready), 1);
    cyc(); resolve_valid = 1'b0; fetch_valid = 1'b0;
    #1;
    chk("t6_request_pre", int'(request), 1);
    chk("t6_result_pre", int'(result), 1);
    chk("t6_mispredict_pre", int'(mispredict), 1);
    rst = 1'b1;
    #1;
    chk("t6_request_rst", int'(request), 0);
    chk("t6_result_rst", int'(result), 0);
    chk("t6_mispredict_rst", int'(mispredict), 0);
    chk("t6_pending_rst", int'(pending), 0);
    chk("t6_resolve_count_rst", int'(resolve_count), 0);
    chk("t6_mispredict_count_rst", int'(mispredict_count), 0);
    rst = 1'b0;
    neg();
    cyc(); resolve_valid = 1'b1; resolve_taken = 1'b1; neg();
    chk("t6_resolve_ready_idle", int'(resolve_ready), 0);
    cyc(); neg();
    chk("t6_ignored_result", int'(result), 0);
    cyc(); resolve_valid = 1'b0; neg();
    chk("t6_ignored_result_b", int'(result), 0);
    chk("t6_ignored_count", int'(resolve_count), 0);

    // Normal operation after reset.
    cyc(); fetch_valid = 1'b1; pq.push_back(1'b1);
    cyc(); fetch_valid = 1'b0;
    cyc(); cyc(); neg();
    chk("t7_resolve_ready", int'(resolve_ready), 1);
    cyc(); resolve_valid = 1'b1; resolve_taken = 1'b1; rq.push_back(2'b10);
    cyc(); resolve_valid = 1'b0; neg();
    chk("t7_resolve_count", int'(resolve_count), 1);
    chk("t7_mispredict_count", int'(mispredict_count), 0);

    cyc(); neg();
    chk("pred_queue_drained", pq.size(), 0);
    chk("resolve_queue_drained", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
